led_seq_ctrl: RTL

- Hardware LED sequencer that owns the board LED pins, so software does not bit-bang them over PS GPIO.
- Per-LED modes: OFF, ON, BLINK (programmable half-period) and PWM (8-bit duty).
- Configured through a valid/ready command port.
- A hardware alarm input overrides all LEDs with a unison blink.
- Outputs are led_o/led_t pairs that feed the board's tristate IO buffer directly (led_t=0 means drive).

---
 rtl/led_seq_pkg.sv | 30 +++
 rtl/led_seq_channel.sv | 74 +++++++
 rtl/led_seq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_pkg
//  Description : Shared definitions for the LED sequencer: LED mode
//                encodings, command FSM state encoding and the helper that
//                maps a programmed blink half-period to its effective value.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    // LED mode encodings as carried on cfg_mode
    localparam logic [1:0] LED_MODE_OFF   = 2'd0;
    localparam logic [1:0] LED_MODE_ON    = 2'd1;
    localparam logic [1:0] LED_MODE_BLINK = 2'd2;
    localparam logic [1:0] LED_MODE_PWM   = 2'd3;

    // Command FSM: IDLE accepts a command, APPLY writes it for one cycle
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } cmd_state_t;

    // A programmed half-period of zero would never toggle; treat it as one.
    function automatic logic [7:0] eff_half(input logic [7:0] arg);
        return (arg == 8'd0) ? 8'd1 : arg;
    endfunction

endpackage : led_seq_pkg
`default_nettype wire

// File: rtl/led_seq_channel.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_channel
//  Description : One LED channel. Holds the channel mode/argument, runs the
//                blink counter and phase, and produces the combinational LED
//                value for the selected mode.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-high reset
//                load       - 1-cycle strobe: capture mode/arg, restart blink
//                mode       - new mode (OFF/ON/BLINK/PWM)
//                arg        - new argument (blink half-period or PWM duty)
//                tick       - 1-cycle timebase pulse
//                pwm_phase  - shared free-running 8-bit PWM phase
//                led        - combinational LED value for this channel
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_channel
    import led_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] mode,
    input  logic [7:0] arg,
    input  logic       tick,
    input  logic [7:0] pwm_phase,
    output logic       led
);

    logic [1:0] r_mode;
    logic [7:0] r_arg;
    logic [7:0] r_blink_cnt;
    logic       r_blink_phase;
    logic [7:0] w_blink_last;

    // Counter value on which the next tick toggles the phase
    assign w_blink_last = eff_half(r_arg) - 8'd1;

    // A load takes priority over a coincident tick: the counter restarts
    // from zero, so that tick is intentionally lost for this channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode        <= LED_MODE_OFF;
            r_arg         <= 8'd0;
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else if (load) begin
            r_mode        <= mode;
            r_arg         <= arg;
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= 1'b1;
        end else if (tick) begin
            if (r_blink_cnt == w_blink_last) begin
                r_blink_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        led = 1'b0;
        case (r_mode)
            LED_MODE_OFF:   led = 1'b0;
            LED_MODE_ON:    led = 1'b1;
            LED_MODE_BLINK: led = r_blink_phase;
            LED_MODE_PWM:   led = (pwm_phase < r_arg);
            default:        led = 1'b0;
        endcase
    end

endmodule : led_seq_channel
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : Hardware LED sequencer. Per-LED OFF/ON/BLINK/PWM modes set
//                through a valid/ready command port, a shared timebase and
//                PWM phase, and an alarm input that overrides every LED with
//                a unison blink. Drives led_o/led_t pairs for a tristate
//                IO buffer (led_t=0 drives the pin).
//  Ports       : clk        - system clock
//                rst        - asynchronous active-high reset
//                cfg_valid  - command valid
//                cfg_ready  - command ready (low during APPLY and reset)
//                cfg_sel    - target LED index
//                cfg_mode   - 0=OFF 1=ON 2=BLINK 3=PWM
//                cfg_arg    - blink half-period in ticks / PWM duty
//                cfg_err    - 1-cycle pulse for a command with bad cfg_sel
//                alarm      - level override request
//                led_o      - registered LED drive values
//                led_t      - registered tristate controls (1=high-Z)
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS   = 3,
    parameter int TICK_DIV   = 100000,
    parameter int ALARM_HALF = 125
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_sel,
    input  logic [1:0]          cfg_mode,
    input  logic [7:0]          cfg_arg,
    output logic                cfg_err,
    input  logic                alarm,
    output logic [NUM_LEDS-1:0] led_o,
    output logic [NUM_LEDS-1:0] led_t
);

    localparam int               c_PRESC_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [7:0]       c_ALARM_LAST  = 8'(ALARM_HALF - 1);

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    cmd_state_t          r_state;
    logic [1:0]          r_sel;
    logic [1:0]          r_mode;
    logic [7:0]          r_arg;
    logic                w_sel_bad;
    logic                w_accept;

    assign w_sel_bad = (int'(cfg_sel) >= NUM_LEDS);
    assign w_accept  = cfg_valid && cfg_ready;

    // cfg_ready stays low for the first cycle after reset release and for
    // each APPLY cycle; cfg_err is raised on acceptance so that it is high
    // exactly during the APPLY cycle of a bad command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            r_sel     <= 2'd0;
            r_mode    <= LED_MODE_OFF;
            r_arg     <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_APPLY;
                        cfg_ready <= 1'b0;
                        cfg_err   <= w_sel_bad;
                        r_sel     <= cfg_sel;
                        r_mode    <= cfg_mode;
                        r_arg     <= cfg_arg;
                    end else begin
                        cfg_ready <= 1'b1;
                        cfg_err   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    r_state   <= ST_IDLE;
                    cfg_ready <= 1'b1;
                    cfg_err   <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    cfg_ready <= 1'b0;
                    cfg_err   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timebase prescaler and shared PWM phase
    // ------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;
    logic [7:0]           r_pwm_phase;
    logic                 w_tick;

    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_pwm_phase <= 8'd0;
        end else begin
            r_presc     <= w_tick ? '0 : (r_presc + 1'b1);
            r_pwm_phase <= r_pwm_phase + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // LED channels
    // ------------------------------------------------------------------
    logic [NUM_LEDS-1:0] w_load;
    logic [NUM_LEDS-1:0] w_chan_led;

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
            // An out-of-range r_sel never matches, so a bad command loads nothing
            assign w_load[gi] = (r_state == ST_APPLY) && (r_sel == 2'(gi));

            led_seq_channel u_chan (
                .clk       (clk),
                .rst       (rst),
                .load      (w_load[gi]),
                .mode      (r_mode),
                .arg       (r_arg),
                .tick      (w_tick),
                .pwm_phase (r_pwm_phase),
                .led       (w_chan_led[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Alarm override
    // ------------------------------------------------------------------
    logic       r_alarm_q;
    logic       r_alarm_phase;
    logic [7:0] r_alarm_cnt;
    logic       w_alarm_rise;

    assign w_alarm_rise = alarm && !r_alarm_q;

    // The rising edge restarts the unison blink in the on phase; it wins
    // over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alarm_q     <= 1'b0;
            r_alarm_phase <= 1'b0;
            r_alarm_cnt   <= 8'd0;
        end else begin
            r_alarm_q <= alarm;
            if (w_alarm_rise) begin
                r_alarm_phase <= 1'b1;
                r_alarm_cnt   <= 8'd0;
            end else if (w_tick) begin
                if (r_alarm_cnt == c_ALARM_LAST) begin
                    r_alarm_cnt   <= 8'd0;
                    r_alarm_phase <= ~r_alarm_phase;
                end else begin
                    r_alarm_cnt   <= r_alarm_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    // Pins float during reset and start driving on the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_o <= '0;
            led_t <= '1;
        end else begin
            led_t <= '0;
            led_o <= r_alarm_q ? {NUM_LEDS{r_alarm_phase}} : w_chan_led;
        end
    end

endmodule : led_seq_ctrl
`default_nettype wire
